// File: rtl/mdu_pkg.sv
// Shared opcode encoding and small helpers for the multiply/divide unit.
package mdu_pkg;

    // md_op encoding; codes 9..15 are not listed and behave like MD_NONE.
    typedef enum logic [3:0] {
        MD_NONE  = 4'd0,
        MD_MULT  = 4'd1,
        MD_MULTU = 4'd2,
        MD_DIV   = 4'd3,
        MD_DIVU  = 4'd4,
        MD_MTHI  = 4'd5,
        MD_MTLO  = 4'd6,
        MD_MFHI  = 4'd7,
        MD_MFLO  = 4'd8
    } md_op_e;

    localparam logic [31:0] INT_MIN = 32'h8000_0000;
    localparam logic [31:0] NEG_ONE = 32'hFFFF_FFFF;

    // True for any real md operation (1..8); out-of-range codes count as NONE.
    function automatic logic md_is_op(input logic [3:0] op);
        return (op != 4'd0) && (op <= 4'd8);
    endfunction

endpackage

// File: rtl/mdu_if.sv
// Execute-stage bundle between the pipeline and the multiply/divide unit.
interface mdu_if;
    logic [3:0]  md_op;
    logic [31:0] rsdata;
    logic [31:0] rtdata;
    logic        busy;
    logic        stall;
    logic [31:0] md_out;
    logic [31:0] hi;
    logic [31:0] lo;

    // Pipeline side: issues operations and operands, observes results.
    modport master (
        output md_op, rsdata, rtdata,
        input  busy, stall, md_out, hi, lo
    );

    // Unit side.
    modport slave (
        input  md_op, rsdata, rtdata,
        output busy, stall, md_out, hi, lo
    );
endinterface

// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit with HI/LO registers. Results are
// computed at issue and held pending; a countdown models the real latency
// and commits them to HI/LO when it expires.
module mdu
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic clk,
    input  logic reset,
    mdu_if.slave bus
);

    localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] MULT_CNT = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [31:0]      hi_reg, hi_next;
    logic [31:0]      lo_reg, lo_next;
    logic [31:0]      pend_hi_reg, pend_hi_next;
    logic [31:0]      pend_lo_reg, pend_lo_next;
    logic             pend_wr_reg, pend_wr_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;

    logic             busy;
    logic [63:0]      prod_s, prod_u;
    logic             div_fix;
    logic signed [31:0] dvd_s, dvs_s, quo_s, rem_s;
    logic [31:0]      dvs_u, quo_u, rem_u;

    assign busy = (cnt_reg != '0);

    // Full-width products: sign- or zero-extend to 64 bits, keep low 64.
    assign prod_s = {{32{bus.rsdata[31]}}, bus.rsdata} * {{32{bus.rtdata[31]}}, bus.rtdata};
    assign prod_u = {32'd0, bus.rsdata} * {32'd0, bus.rtdata};

    // Divisor is forced to 1 for divide-by-zero (result discarded anyway) and
    // for INT_MIN / -1, where dividing by 1 yields the required LO=INT_MIN, HI=0
    // without relying on overflow behaviour of the divider.
    assign div_fix = (bus.rtdata == 32'd0) ||
                     ((bus.rsdata == INT_MIN) && (bus.rtdata == NEG_ONE));
    assign dvd_s   = $signed(bus.rsdata);
    assign dvs_s   = div_fix ? 32'sd1 : $signed(bus.rtdata);
    assign quo_s   = dvd_s / dvs_s;
    assign rem_s   = dvd_s % dvs_s;

    assign dvs_u   = (bus.rtdata == 32'd0) ? 32'd1 : bus.rtdata;
    assign quo_u   = bus.rsdata / dvs_u;
    assign rem_u   = bus.rsdata % dvs_u;

    // Next-state: countdown/commit while busy, otherwise accept the issued op.
    always_comb begin
        hi_next      = hi_reg;
        lo_next      = lo_reg;
        pend_hi_next = pend_hi_reg;
        pend_lo_next = pend_lo_reg;
        pend_wr_next = pend_wr_reg;
        cnt_next     = cnt_reg;

        if (busy) begin
            cnt_next = cnt_reg - CNT_ONE;
            if ((cnt_reg == CNT_ONE) && pend_wr_reg) begin
                hi_next = pend_hi_reg;
                lo_next = pend_lo_reg;
            end
        end else begin
            case (bus.md_op)
                MD_MULT: begin
                    pend_hi_next = prod_s[63:32];
                    pend_lo_next = prod_s[31:0];
                    pend_wr_next = 1'b1;
                    cnt_next     = MULT_CNT;
                end
                MD_MULTU: begin
                    pend_hi_next = prod_u[63:32];
                    pend_lo_next = prod_u[31:0];
                    pend_wr_next = 1'b1;
                    cnt_next     = MULT_CNT;
                end
                MD_DIV: begin
                    pend_hi_next = rem_s;
                    pend_lo_next = quo_s;
                    pend_wr_next = (bus.rtdata != 32'd0);
                    cnt_next     = DIV_CNT;
                end
                MD_DIVU: begin
                    pend_hi_next = rem_u;
                    pend_lo_next = quo_u;
                    pend_wr_next = (bus.rtdata != 32'd0);
                    cnt_next     = DIV_CNT;
                end
                MD_MTHI: hi_next = bus.rsdata;
                MD_MTLO: lo_next = bus.rsdata;
                default: ;
            endcase
        end
    end

    // State registers; reset (active low) also abandons any pending result.
    always_ff @(posedge clk) begin
        if (!reset) begin
            hi_reg      <= '0;
            lo_reg      <= '0;
            pend_hi_reg <= '0;
            pend_lo_reg <= '0;
            pend_wr_reg <= 1'b0;
            cnt_reg     <= '0;
        end else begin
            hi_reg      <= hi_next;
            lo_reg      <= lo_next;
            pend_hi_reg <= pend_hi_next;
            pend_lo_reg <= pend_lo_next;
            pend_wr_reg <= pend_wr_next;
            cnt_reg     <= cnt_next;
        end
    end

    // MFHI/MFLO read mux; zero for every other op.
    always_comb begin
        bus.md_out = 32'd0;
        case (bus.md_op)
            MD_MFHI: bus.md_out = hi_reg;
            MD_MFLO: bus.md_out = lo_reg;
            default: ;
        endcase
    end

    assign bus.busy  = busy;
    assign bus.stall = busy & md_is_op(bus.md_op);
    assign bus.hi    = hi_reg;
    assign bus.lo    = lo_reg;

endmodule

// File: tb/tb_mdu.sv
// Directed bench for mdu: a vector table of single operations followed by
// hand-written sequences for stall, MTHI->MFHI and reset-abort behaviour.
module tb_mdu;
    import mdu_pkg::*;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    mdu_if bus();

    mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] rs;
        logic [31:0] rt;
        int          cycles;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%08h expected=%08h", name, act, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int cyc;

        checks = 0;
        errors = 0;

        // op, rs, rt, busy cycles, expected hi, expected lo (state carries over)
        vecs[0]  = '{MD_MULT,  32'hFFFF_FFFE, 32'd3,         5,  32'hFFFF_FFFF, 32'hFFFF_FFFA};
        vecs[1]  = '{MD_MULTU, 32'hFFFF_FFFE, 32'd3,         5,  32'h0000_0002, 32'hFFFF_FFFA};
        vecs[2]  = '{MD_DIV,   32'hFFFF_FFF9, 32'd2,         10, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[3]  = '{MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0000_0000, 32'h8000_0000};
        vecs[4]  = '{MD_DIVU,  32'd100,       32'd7,         10, 32'd2,         32'd14};
        vecs[5]  = '{MD_MTHI,  32'h1234_5678, 32'd0,         0,  32'h1234_5678, 32'd14};
        vecs[6]  = '{MD_MTLO,  32'hCAFE_F00D, 32'd0,         0,  32'h1234_5678, 32'hCAFE_F00D};
        vecs[7]  = '{MD_DIVU,  32'd7,         32'd0,         10, 32'h1234_5678, 32'hCAFE_F00D};
        vecs[8]  = '{MD_DIV,   32'hFFFF_FFF9, 32'd0,         10, 32'h1234_5678, 32'hCAFE_F00D};
        vecs[9]  = '{MD_MULT,  32'h8000_0000, 32'h8000_0000, 5,  32'h4000_0000, 32'h0000_0000};
        vecs[10] = '{MD_DIV,   32'd7,         32'hFFFF_FFFE, 10, 32'd1,         32'hFFFF_FFFD};
        vecs[11] = '{4'd9,     32'hDEAD_BEEF, 32'd5,         0,  32'd1,         32'hFFFF_FFFD};

        bus.md_op  = MD_NONE;
        bus.rsdata = '0;
        bus.rtdata = '0;
        reset      = 1'b0;
        tick();
        tick();
        reset = 1'b1;

        // Reset state and MFLO after reset.
        chk("reset_hi", bus.hi, 32'd0);
        chk("reset_lo", bus.lo, 32'd0);
        chk("reset_busy", {31'd0, bus.busy}, 32'd0);
        bus.md_op = MD_MFLO;
        #1;
        chk("reset_mflo", bus.md_out, 32'd0);
        chk("reset_stall", {31'd0, bus.stall}, 32'd0);

        // Vector table: issue for one edge, count busy cycles, check HI/LO.
        for (int i = 0; i < 12; i++) begin
            bus.md_op  = vecs[i].op;
            bus.rsdata = vecs[i].rs;
            bus.rtdata = vecs[i].rt;
            tick();
            bus.md_op = MD_NONE;
            cyc = 0;
            while (bus.busy === 1'b1 && cyc < 50) begin
                cyc++;
                tick();
            end
            chk($sformatf("v%0d_cycles", i), cyc, vecs[i].cycles);
            chk($sformatf("v%0d_hi", i), bus.hi, vecs[i].exp_hi);
            chk($sformatf("v%0d_lo", i), bus.lo, vecs[i].exp_lo);
            $display("vec %0d op=%0d rs=%08h rt=%08h cycles=%0d hi=%08h lo=%08h",
                     i, vecs[i].op, vecs[i].rs, vecs[i].rt, cyc, bus.hi, bus.lo);
        end

        // MTHI then MFHI on the next cycle.
        bus.md_op  = MD_MTHI;
        bus.rsdata = 32'h1234_5678;
        tick();
        bus.md_op = MD_MFHI;
        #1;
        chk("mfhi_stall", {31'd0, bus.stall}, 32'd0);
        chk("mfhi_data", bus.md_out, 32'h1234_5678);
        $display("seq mthi->mfhi md_out=%08h", bus.md_out);

        // MULT 6x7 with an MTLO held behind it.
        bus.md_op  = MD_MULT;
        bus.rsdata = 32'd6;
        bus.rtdata = 32'd7;
        tick();
        bus.md_op  = MD_MTLO;
        bus.rsdata = 32'h0000_AAAA;
        #1;
        cyc = 0;
        while (bus.busy === 1'b1 && cyc < 50) begin
            cyc++;
            chk($sformatf("hold_stall_c%0d", cyc), {31'd0, bus.stall}, 32'd1);
            tick();
        end
        chk("hold_cycles", cyc, 5);
        chk("hold_stall_free", {31'd0, bus.stall}, 32'd0);
        chk("hold_lo_mult", bus.lo, 32'd42);
        chk("hold_hi_mult", bus.hi, 32'd0);
        tick();
        bus.md_op = MD_NONE;
        chk("hold_lo_mtlo", bus.lo, 32'h0000_AAAA);
        $display("seq mult+held mtlo cycles=%0d lo=%08h", cyc, bus.lo);

        // DIV aborted by reset on its fourth busy cycle.
        bus.md_op  = MD_DIV;
        bus.rsdata = 32'd100;
        bus.rtdata = 32'd7;
        tick();
        bus.md_op = MD_NONE;
        chk("abort_busy_start", {31'd0, bus.busy}, 32'd1);
        tick();
        tick();
        tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        chk("abort_busy", {31'd0, bus.busy}, 32'd0);
        chk("abort_stall", {31'd0, bus.stall}, 32'd0);
        chk("abort_hi", bus.hi, 32'd0);
        chk("abort_lo", bus.lo, 32'd0);
        for (int k = 0; k < 15; k++) tick();
        chk("abort_late_hi", bus.hi, 32'd0);
        chk("abort_late_lo", bus.lo, 32'd0);
        chk("abort_late_busy", {31'd0, bus.busy}, 32'd0);
        $display("seq div reset-abort hi=%08h lo=%08h", bus.hi, bus.lo);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mdu.md
Name: mdu

Overview:
- Multi-cycle multiply/divide unit with HI/LO registers.
- Sits beside the ALU in the execute path. It consumes rsdata/rtdata read from the register file and feeds MFHI/MFLO results to GRF writeback.
- Models real mult/div latency with a busy countdown.
- Raises a stall request so the front end (PC/NPC) holds a dependent instruction until HI/LO are valid.

Parameters:
- MULT_CYCLES, 5, busy cycles for MULT/MULTU (must be ≥1).
- DIV_CYCLES, 10, busy cycles for DIV/DIVU (must be ≥1).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset: 0 resets on the next rising clk edge.
- md_op  in  4  operation code: 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MFHI, 8 MFLO; codes 9–15 are treated as NONE.
- rsdata  in  32  operand A / MTHI/MTLO source.
- rtdata  in  32  operand B.
- busy  out  1  a mult/div is in flight.
- stall  out  1  the current md_op cannot be accepted this cycle; upstream must hold the instruction.
- md_out  out  32  MFHI/MFLO read data for GRF writeback.
- hi  out  32  current HI register.
- lo  out  32  current LO register.

Behaviour:
- Reset (reset=0 at a clk edge): hi=0, lo=0, busy=0, counter=0, pending results cleared. A reset during an operation aborts it; no late HI/LO write occurs.
- Start: when busy=0 and md_op∈{1..4} at edge E0:
  - compute and latch pending HI/LO results;
  - counter := N (MULT_CYCLES or DIV_CYCLES); busy=1 from E0.
- Countdown: each subsequent edge decrements counter. At the edge where counter==1:
  - hi/lo := pending values; busy := 0.
  - busy is therefore high for exactly N cycles, and new hi/lo are visible the first cycle busy=0.
- MULT: signed 32×32→64 product; HI=upper 32 bits, LO=lower 32 bits. MULTU: the same, unsigned.
- DIV: signed division.
  - LO = quotient, truncated toward zero; HI = remainder, with the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- DIVU: unsigned division; LO = quotient, HI = remainder.
- Divide by zero (DIV or DIVU, rt=0): hi/lo are left unchanged at completion; busy still runs the full DIV_CYCLES.
- MTHI/MTLO with busy=0: hi or lo := rsdata at that edge; no busy.
- MFHI/MFLO: md_out = hi or lo combinationally; otherwise md_out=0.
- Stall: stall = busy & (md_op≠NONE), combinational.
  - While busy, every md_op (including MTHI/MTLO/MFHI/MFLO and a new start) is ignored: no state change, and stale md_out is don't-care.
  - The upstream stage holds the instruction and reissues it the first cycle busy=0.
- Back-to-back:
  - A start presented in the cycle busy first reads 0 is accepted at that edge, with no bubble.
  - Completion and a new start never coincide, because a start is only accepted with busy=0.
- Consecutive MTHI then MFHI: MFHI on the following cycle returns the new value. There is no same-cycle bypass, since only one md_op is issued per cycle.

Decomposition:
- MD_NONE..MD_MFLO opcode constants (4-bit) go in the shared define.v, alongside the existing opcode/funct defines.
- The opcode/funct→md_op decode lives in the controller, not here.
- No sub-module: arithmetic, countdown and HI/LO registers live in one module (≈150–200 lines). The multiplier and divider are behavioural `*`, `/` and `%` on latched operands.

Test Plan:
- MULT rs=0xFFFFFFFE, rt=3 → busy=1 for 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA. MULTU with the same operands → hi=0x00000002, lo=0xFFFFFFFA.
- DIV rs=0xFFFFFFF9 (−7), rt=2 → busy 10 cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 0x80000000 by 0xFFFFFFFF → lo=0x80000000, hi=0.
- MTHI 0x12345678 and MTLO 0xCAFEF00D, then DIVU rs=7, rt=0 → after 10 cycles hi=0x12345678, lo=0xCAFEF00D (unchanged).
- MTHI 0x12345678, next cycle MFHI → stall=0, md_out=0x12345678; MFLO after reset → md_out=0.
- MULT 6×7, then MTLO 0xAAAA on the following cycle → stall=1 for the remaining busy cycles and MTLO is ignored; on the first cycle with busy=0 lo=42 and hi=0, and a reissued MTLO then sets lo=0xAAAA.
- Start DIV, drive reset=0 on cycle 4 of busy → next cycle busy=0, hi=lo=0, stall=0; no HI/LO update appears afterwards.
